// File: rtl/sha256_pkg.sv
// Shared constants, state encoding and helpers for the SHA-256 message padder.
package sha256_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned BLK_W     = 512;
  localparam int unsigned BLK_WORDS = 16;
  localparam logic [7:0]  PAD_BYTE  = 8'h80;

  typedef enum logic [1:0] {S_FILL, S_EMIT, S_EXTRA} state_e;

  function automatic logic [WORD_W-1:0] byte_swap(input logic [WORD_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// Masks a message word to its valid leading bytes and inserts the 0x80 marker after them.
module sha256_pad_word
  import sha256_pkg::*;
#(
  parameter bit ByteSwap = 1'b0
) (
  input  logic [WORD_W-1:0] word_i,
  input  logic [2:0]        nbytes_i,
  output logic [WORD_W-1:0] word_o,
  output logic              ovf_o
);

  logic [WORD_W-1:0] w;
  logic [2:0]        n;

  always_comb begin
    w      = ByteSwap ? byte_swap(word_i) : word_i;
    n      = (nbytes_i > 3'd4) ? 3'd4 : nbytes_i;
    word_o = '0;
    // Byte 0 is the MSB; a full word leaves no room, so the marker spills to the next slot.
    for (int b = 0; b < 4; b++) begin
      if (3'(b) < n) begin
        word_o[31-8*b -: 8] = w[31-8*b -: 8];
      end else if (3'(b) == n) begin
        word_o[31-8*b -: 8] = PAD_BYTE;
      end
    end
    ovf_o = (n == 3'd4);
  end

endmodule

// File: rtl/sha256_msg_pad.sv
// SHA-256 message padder: packs 32-bit words into padded 512-bit blocks with first/last flags.
// Define SHA256_PAD_BYTESWAP_EN to take the first message byte from in_data[7:0].
module sha256_msg_pad
  import sha256_pkg::*;
#(
  parameter int unsigned LEN_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  input  logic [2:0]        in_bytes,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic [BLK_W-1:0]  blk_data,
  output logic              blk_first,
  output logic              blk_last
);

`ifdef SHA256_PAD_BYTESWAP_EN
  localparam bit ByteSwap = 1'b1;
`else
  localparam bit ByteSwap = 1'b0;
`endif

  state_e                                state_q, state_d;
  logic [3:0]                            wcnt_q, wcnt_d;
  logic [LEN_W-1:0]                      bitlen_q, bitlen_d;
  logic [BLK_WORDS-1:0][WORD_W-1:0]      blk_q, blk_d;
  logic                                  pending_q, pending_d;
  logic                                  extra_q, extra_d;
  logic                                  first_q, first_d;
  logic                                  last_q, last_d;

  logic [WORD_W-1:0] pad_word;
  logic              pad_ovf;
  logic [2:0]        nb;
  logic [4:0]        pad_slot;
  logic [63:0]       len64;
  logic              accept;

  sha256_pad_word #(
    .ByteSwap (ByteSwap)
  ) u_pad_word (
    .word_i   (in_data),
    .nbytes_i (in_last ? in_bytes : 3'd4),
    .word_o   (pad_word),
    .ovf_o    (pad_ovf)
  );

  assign in_ready  = (state_q == S_FILL) && !reset;
  assign blk_valid = (state_q == S_EMIT);
  assign blk_data  = blk_q;
  assign blk_first = blk_valid && first_q;
  assign blk_last  = blk_valid && last_q;
  assign accept    = in_valid && in_ready;
  assign nb        = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
  assign pad_slot  = {1'b0, wcnt_q} + {4'b0, pad_ovf};

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    bitlen_d  = bitlen_q;
    blk_d     = blk_q;
    pending_d = pending_q;
    extra_d   = extra_q;
    first_d   = first_q;
    last_d    = last_q;
    len64     = 64'(bitlen_q);
    unique case (state_q)
      S_FILL: begin
        if (accept) begin
          blk_d[wcnt_q] = pad_word;
          if (!in_last) begin
            wcnt_d   = wcnt_q + 4'd1;
            bitlen_d = bitlen_q + LEN_W'(32);
            if (wcnt_q == 4'd15) begin
              state_d = S_EMIT;
              last_d  = 1'b0;
              extra_d = 1'b0;
            end
          end else begin
            bitlen_d = bitlen_q + LEN_W'({nb, 3'b000});
            len64    = 64'(bitlen_d);
            for (int k = 0; k < BLK_WORDS; k++) begin
              if (k > int'(wcnt_q)) blk_d[k] = '0;
            end
            if (pad_ovf && (wcnt_q != 4'd15)) blk_d[wcnt_q + 4'd1] = {PAD_BYTE, 24'h0};
            state_d = S_EMIT;
            if (pad_slot <= 5'd13) begin
              blk_d[14] = len64[63:32];
              blk_d[15] = len64[31:0];
              last_d    = 1'b1;
              extra_d   = 1'b0;
            end else begin
              // No room for the length here; a trailing block carries it.
              last_d    = 1'b0;
              extra_d   = 1'b1;
              pending_d = (pad_slot == 5'd16);
            end
          end
        end
      end
      S_EMIT: begin
        if (blk_ready) begin
          first_d = 1'b0;
          if (last_q) begin
            wcnt_d    = '0;
            bitlen_d  = '0;
            pending_d = 1'b0;
            first_d   = 1'b1;
            state_d   = S_FILL;
          end else if (extra_q) begin
            state_d = S_EXTRA;
          end else begin
            wcnt_d  = '0;
            state_d = S_FILL;
          end
        end
      end
      S_EXTRA: begin
        blk_d     = '0;
        if (pending_q) blk_d[0] = {PAD_BYTE, 24'h0};
        blk_d[14] = len64[63:32];
        blk_d[15] = len64[31:0];
        wcnt_d    = '0;
        extra_d   = 1'b0;
        last_d    = 1'b1;
        state_d   = S_EMIT;
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FILL;
      wcnt_q    <= '0;
      bitlen_q  <= '0;
      blk_q     <= '0;
      pending_q <= 1'b0;
      extra_q   <= 1'b0;
      first_q   <= 1'b1;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      bitlen_q  <= bitlen_d;
      blk_q     <= blk_d;
      pending_q <= pending_d;
      extra_q   <= extra_d;
      first_q   <= first_d;
      last_q    <= last_d;
    end
  end

endmodule

// File: tb/tb_sha256_msg_pad.sv
// Scoreboard bench for sha256_msg_pad: byte-level FIPS 180-4 padding model vs. emitted blocks.
module tb_sha256_msg_pad;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [2:0]   in_bytes;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;

  typedef struct {
    logic [511:0] data;
    bit           first;
    bit           last;
  } blk_t;

  blk_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   hold   = 0;

  sha256_msg_pad dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .blk_last  (blk_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input logic [511:0] act,
                     input logic [511:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: standard byte-oriented padding, then slice into 64-byte blocks.
  function automatic void model(input byte unsigned msg[$]);
    byte unsigned p[$];
    logic [63:0]  bits;
    blk_t         b;
    int           nblk;
    p    = msg;
    bits = 64'(msg.size()) << 3;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    nblk = p.size() / 64;
    for (int j = 0; j < nblk; j++) begin
      b.data = '0;
      for (int k = 0; k < 16; k++)
        b.data[32*k +: 32] = {p[64*j+4*k], p[64*j+4*k+1], p[64*j+4*k+2], p[64*j+4*k+3]};
      b.first = (j == 0);
      b.last  = (j == nblk - 1);
      exp_q.push_back(b);
    end
  endfunction

  task automatic send_word(input byte unsigned b0, input byte unsigned b1,
                           input byte unsigned b2, input byte unsigned b3,
                           input bit last, input logic [2:0] nbytes);
    bit rdy;
    bit done = 0;
`ifdef SHA256_PAD_BYTESWAP_EN
    in_data = {b3, b2, b1, b0};
`else
    in_data = {b0, b1, b2, b3};
`endif
    in_last  = last;
    in_bytes = nbytes;
    in_valid = 1'b1;
    for (int c = 0; c < 500; c++) begin
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        done = 1;
        break;
      end
    end
    if (!done) chk(1'b0, "in_ready_timeout", 0, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  function automatic byte unsigned mb(input byte unsigned msg[$], input int i);
    return (i < msg.size()) ? msg[i] : 8'($urandom);
  endfunction

  task automatic send_msg(input byte unsigned msg[$], input bit empty_tail);
    int len   = msg.size();
    int nfull = len / 4;
    int rem   = len % 4;
    int nw;
    if (len == 0) begin
      send_word(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 3'd0);
    end else if (rem != 0 || empty_tail) begin
      nw = (rem != 0) ? nfull + 1 : nfull + 1;
      for (int w = 0; w < nw; w++)
        send_word(mb(msg, 4*w), mb(msg, 4*w+1), mb(msg, 4*w+2), mb(msg, 4*w+3),
                  w == nw - 1, (w == nw - 1) ? 3'(rem) : 3'($urandom));
    end else begin
      for (int w = 0; w < nfull; w++)
        send_word(msg[4*w], msg[4*w+1], msg[4*w+2], msg[4*w+3], w == nfull - 1,
                  (w == nfull - 1) ? 3'($urandom_range(4, 7)) : 3'($urandom));
    end
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 3000; c++) begin
      if (exp_q.size() == 0 && !blk_valid) break;
      @(posedge clk);
      #1;
    end
    chk(exp_q.size() == 0, "drain_timeout", exp_q.size(), 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk(in_ready == 1'b0, {tag, "_in_ready"}, in_ready, 0);
    chk(blk_valid == 1'b0, {tag, "_blk_valid"}, blk_valid, 0);
    chk(blk_data == '0, {tag, "_blk_data"}, blk_data, 0);
    chk(blk_first == 1'b0 && blk_last == 1'b0, {tag, "_flags"}, {blk_first, blk_last}, 0);
  endtask

  // Consumer readiness: random, or held low for a forced stall.
  initial begin
    blk_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (hold > 0) begin
        blk_ready = 1'b0;
        hold--;
      end else begin
        blk_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: every valid cycle is compared to the queue head, so stalls check stability too.
  always @(negedge clk) begin
    if (!reset && blk_valid) begin
      chk(in_ready == 1'b0, "in_ready_during_emit", in_ready, 0);
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_block", blk_data, 0);
      end else begin
        chk(blk_data == exp_q[0].data, "blk_data", blk_data, exp_q[0].data);
        chk(blk_first == exp_q[0].first, "blk_first", blk_first, exp_q[0].first);
        chk(blk_last == exp_q[0].last, "blk_last", blk_last, exp_q[0].last);
        if (blk_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    byte unsigned msg[$];
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    byte unsigned msg[$];
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    in_bytes = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    reset = 1'b0;
    #1;
    chk(in_ready == 1'b1, "in_ready_after_reset", in_ready, 1);
    @(posedge clk);
    #1;

    msg = '{8'h61, 8'h62, 8'h63};
    model(msg);
    send_msg(msg, 1'b0);
    wait_drain();

    msg = '{};
    model(msg);
    send_msg(msg, 1'b0);
    wait_drain();

    // 56 bytes, then a forced stall while the next message is already being offered.
    msg = '{};
    for (int i = 0; i < 56; i++) msg.push_back(8'($urandom));
    model(msg);
    send_msg(msg, 1'b0);
    hold = 7;
    msg = '{8'h61, 8'h62, 8'h63};
    model(msg);
    send_msg(msg, 1'b0);
    wait_drain();

    msg = '{};
    for (int i = 0; i < 64; i++) msg.push_back(8'($urandom));
    model(msg);
    send_msg(msg, 1'b0);
    wait_drain();

    // Abort a message after 7 words; nothing from it may ever appear.
    for (int w = 0; w < 7; w++)
      send_word(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 3'd4);
    #2;
    reset = 1'b1;
    #1;
    chk_outputs_zero("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    msg = '{8'h61, 8'h62, 8'h63};
    model(msg);
    send_msg(msg, 1'b0);
    wait_drain();

    for (int m = 0; m < 25; m++) begin
      msg = '{};
      for (int i = 0, n = $urandom_range(0, 200); i < n; i++) msg.push_back(8'($urandom));
      model(msg);
      send_msg(msg, 1'($urandom));
    end
    wait_drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
